tdc_phase_accumulator: RTL and testbench
========================================

Name: tdc_phase_accumulator

Overview:
- Downstream consumer of the inverter-chain TDC sensor output in the microtile sensor tile.
- Samples the sensor's delayed clock with the system clock through a synchronizer over a programmable window.
- Accumulates high-sample count (phase/duty estimate) and transition count (jitter estimate).
- Presents both counts through a valid/ready result interface that the top level drives onto uo_out/uio_out.

Parameters:
- WINDOW_W, 8, width of window_len; the window holds 1 to 2^WINDOW_W samples.
- CNT_W, 9, width of each result counter; saturates at 2^CNT_W-1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable; when low, all state holds.
- delayed_clk_i  input  1  asynchronous delayed clock from the sensor.
- start  input  1  single-cycle request to begin a measurement.
- window_len  input  WINDOW_W  sample count, latched on an accepted start; 0 means 2^WINDOW_W.
- result_ready  input  1  consumer accepts the result.
- result_valid  output  1  hit_count and edge_count are valid.
- hit_count  output  CNT_W  number of samples equal to 1.
- edge_count  output  CNT_W  number of sample-to-sample changes.
- busy  output  1  high in SETTLE and ACCUM.
- overrun  output  1  sticky flag: a start was dropped.

Behaviour:
- Reset (async assert, sync release through normal flops): FSM=IDLE; synchronizer, counters and latched window are 0; all outputs 0.
- The synchronizer is a SYNC_STAGES-flop chain on delayed_clk_i; s denotes its output. The first flop is the only one that sees the async input.
- ena=0: FSM, counters and handshake outputs freeze. The synchronizer keeps running.
- FSM states: IDLE, SETTLE, ACCUM, DONE.
- IDLE: start=1 latches window_len, clears both counters and overrun, and moves to SETTLE.
- SETTLE: lasts exactly SYNC_STAGES cycles. Samples are discarded, except that the last SETTLE sample is stored as prev.
- ACCUM: lasts exactly N cycles, where N is the latched length (0 maps to 2^WINDOW_W). Each cycle, hit_count increments if s=1 and edge_count increments if s!=prev; then prev<=s. After the Nth sample the FSM moves to DONE.
- Saturation: each counter stops at 2^CNT_W-1 and never wraps.
- Latency: results are valid SYNC_STAGES+N cycles after the cycle in which start is accepted (result_valid rises on the following edge).
- DONE: result_valid=1. Counts hold stable until result_valid&&result_ready.
  - On a handshake without start: go to IDLE and drop result_valid.
  - On a handshake with start in the same cycle: accept the new measurement, go directly to SETTLE, and clear overrun.
- start in SETTLE or ACCUM, or in DONE without result_ready: the start is ignored and overrun<=1. overrun holds until the next accepted start.
- result_ready outside DONE has no effect.
- busy=1 exactly when the FSM is in SETTLE or ACCUM.
- Reset mid-measurement aborts immediately to the reset state. No partial result is produced.
- window_len changes after start is accepted have no effect on the running measurement.

Decomposition:
- Shared package tdc_pkg holds:
  - the state enum (IDLE/SETTLE/ACCUM/DONE);
  - default constants TDC_WINDOW_W=8, TDC_CNT_W=9, TDC_SYNC_STAGES=2;
  - a saturating-increment function.
- One sub-module, tdc_sync, is the parameterized SYNC_STAGES flop synchronizer with async active-low reset. It is reused wherever sensor outputs cross into clk.

Test Plan:
- delayed_clk_i held 1, window_len=10, start pulse → busy for 12 cycles, then result_valid with hit=10, edge=0.
- delayed_clk_i toggled on each negedge clk (alternates per sample, settle ends at 0), window_len=10 → hit=5, edge=10.
- delayed_clk_i held 1, window_len=0 → hit=256, edge=0, valid after 258 cycles.
- CNT_W=4, delayed_clk_i held 1, window_len=40 → hit saturates at 15, edge=0.
- start during ACCUM → result unchanged and overrun=1. In DONE, with result_ready low for 5 cycles, counts stay stable. result_ready+start in the same cycle → new SETTLE begins and overrun clears.
- rst_n pulsed low during ACCUM → all outputs 0 immediately (asynchronously). A following start produces correct fresh counts.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types, default sizes and helpers for the TDC phase accumulator tile.
package tdc_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } tdc_state_t;

  localparam int TDC_WINDOW_W    = 8;
  localparam int TDC_CNT_W       = 9;
  localparam int TDC_SYNC_STAGES = 2;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/tdc_sync.sv
// Multi-flop synchronizer bringing an asynchronous sensor output into clk.
// Only r_chain[0] ever samples the asynchronous input.
module tdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_chain;

  // Shift the async input through the flop chain every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/tdc_phase_accumulator.sv
// Samples the sensor's delayed clock over a programmable window and reports
// the number of high samples and of sample-to-sample transitions.
//
// Result handshake: result_valid rises when a window completes and the counts
// hold until result_valid && result_ready is seen on a clock edge with ena=1;
// result_ready has no effect while result_valid is low.
module tdc_phase_accumulator
  import tdc_pkg::*;
#(
  parameter int WINDOW_W    = TDC_WINDOW_W,
  parameter int CNT_W       = TDC_CNT_W,
  parameter int SYNC_STAGES = TDC_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                delayed_clk_i,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                result_ready,
  output logic                result_valid,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    edge_count,
  output logic                busy,
  output logic                overrun,
  output tdc_state_t          dbg_state
);

  localparam int                 LEN_W    = WINDOW_W + 1;
  localparam int                 SET_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [LEN_W-1:0]   LEN_FULL = {1'b1, {WINDOW_W{1'b0}}};

  logic                w_s;
  logic                w_accept;
  logic [CNT_W-1:0]    w_hit_inc;
  logic [CNT_W-1:0]    w_edge_inc;
  logic [LEN_W-1:0]    w_len;

  tdc_state_t          r_state;
  logic [SET_W-1:0]    r_settle_left;
  logic [LEN_W-1:0]    r_accum_left;
  logic [WINDOW_W-1:0] r_win;
  logic                r_prev;
  logic [CNT_W-1:0]    r_hit;
  logic [CNT_W-1:0]    r_edge;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;

  tdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (delayed_clk_i),
    .q_o   (w_s)
  );

  // A start is taken from IDLE, or from DONE when the pending result is
  // consumed in the same cycle; anywhere else it is dropped.
  assign w_accept   = start && ((r_state == IDLE) ||
                                ((r_state == DONE) && result_ready));
  assign w_hit_inc  = CNT_W'(sat_inc(32'(r_hit),  32'(CNT_MAX)));
  assign w_edge_inc = CNT_W'(sat_inc(32'(r_edge), 32'(CNT_MAX)));
  // A latched length of zero encodes the full 2^WINDOW_W window.
  assign w_len      = (r_win == '0) ? LEN_FULL : {1'b0, r_win};

  // Measurement sequencer with its counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_settle_left <= '0;
      r_accum_left  <= '0;
      r_win         <= '0;
      r_prev        <= 1'b0;
      r_hit         <= '0;
      r_edge        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        r_state       <= SETTLE;
        r_win         <= window_len;
        r_settle_left <= SET_W'(SYNC_STAGES);
        r_hit         <= '0;
        r_edge        <= '0;
        r_valid       <= 1'b0;
        r_busy        <= 1'b1;
        r_overrun     <= 1'b0;
      end else begin
        if (start) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          SETTLE: begin
            // Flush stale synchronizer contents; keep only the final sample
            // as the reference for the first transition check.
            if (r_settle_left == SET_W'(1)) begin
              r_prev       <= w_s;
              r_accum_left <= w_len;
              r_state      <= ACCUM;
            end else begin
              r_settle_left <= r_settle_left - SET_W'(1);
            end
          end
          ACCUM: begin
            if (w_s) begin
              r_hit <= w_hit_inc;
            end
            if (w_s != r_prev) begin
              r_edge <= w_edge_inc;
            end
            r_prev <= w_s;
            if (r_accum_left == LEN_W'(1)) begin
              r_state <= DONE;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_accum_left <= r_accum_left - LEN_W'(1);
            end
          end
          DONE: begin
            if (result_ready) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign result_valid = r_valid;
  assign hit_count    = r_hit;
  assign edge_count   = r_edge;
  assign busy         = r_busy;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_tdc_phase_accumulator.sv
// Bench for tdc_phase_accumulator: a default-sized instance and a CNT_W=4
// instance share all inputs; each has its own expected-result queue.
module tb_tdc_phase_accumulator;
  import tdc_pkg::*;

  localparam int WW   = 8;
  localparam int CW   = 9;
  localparam int CW_S = 4;
  localparam int SS   = 2;

  // ---------------- clock / reset ----------------
  logic clk          = 1'b0;
  logic rst_n        = 1'b0;
  logic ena          = 1'b0;
  logic dclk         = 1'b0;
  logic start        = 1'b0;
  logic result_ready = 1'b0;
  logic [WW-1:0] window_len = '0;

  always #5 clk = ~clk;

  logic            result_valid, busy, overrun;
  logic [CW-1:0]   hit_count, edge_count;
  tdc_state_t      dbg_state;
  logic            result_valid_s, busy_s, overrun_s;
  logic [CW_S-1:0] hit_count_s, edge_count_s;
  tdc_state_t      dbg_state_s;

  tdc_phase_accumulator #(.WINDOW_W(WW), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .delayed_clk_i(dclk), .start(start),
    .window_len(window_len), .result_ready(result_ready),
    .result_valid(result_valid), .hit_count(hit_count), .edge_count(edge_count),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  tdc_phase_accumulator #(.WINDOW_W(WW), .CNT_W(CW_S), .SYNC_STAGES(SS)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .delayed_clk_i(dclk), .start(start),
    .window_len(window_len), .result_ready(result_ready),
    .result_valid(result_valid_s), .hit_count(hit_count_s), .edge_count(edge_count_s),
    .busy(busy_s), .overrun(overrun_s), .dbg_state(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*CW-1:0]   exp_q[$];
  logic [2*CW_S-1:0] exp_s_q[$];

  // seq[0] is the input level at the accepting edge, seq[i] the level at the
  // i-th edge after it.
  logic seq [0:256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Monitor: compares each consumed result against the head of its queue.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && ena && result_ready) begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected", 32'(1), 32'(0));
        end else begin
          logic [2*CW-1:0] ev;
          ev = exp_q.pop_front();
          check("mon_hit",  32'(hit_count),  32'(ev[2*CW-1:CW]));
          check("mon_edge", 32'(edge_count), 32'(ev[CW-1:0]));
        end
      end
      if (result_valid_s) begin
        if (exp_s_q.size() == 0) begin
          check("mon_s_unexpected", 32'(1), 32'(0));
        end else begin
          logic [2*CW_S-1:0] es;
          es = exp_s_q.pop_front();
          check("mon_s_hit",  32'(hit_count_s),  32'(es[2*CW_S-1:CW_S]));
          check("mon_s_edge", 32'(edge_count_s), 32'(es[CW_S-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_const(input logic v);
    for (int i = 0; i <= 256; i++) seq[i] = v;
  endtask

  task automatic fill_alt();
    for (int i = 0; i <= 256; i++) seq[i] = 1'(i % 2);
  endtask

  task automatic fill_rand();
    for (int i = 0; i <= 256; i++) seq[i] = 1'($urandom_range(0, 1));
  endtask

  // One measurement: hits are the ones among seq[1..n], edges the changes
  // along seq[0..n]. ena gaps are only used with a constant seq.
  task automatic run_meas(input logic [WW-1:0] wl, input int ready_delay,
                          input bit hold, input bit chained, input int ovr_at,
                          input int gap_at, input int gap_len);
    int n, h, e, busy_cnt, c, limit, want;
    bit got;
    n = (wl == '0) ? (1 << WW) : int'(wl);
    h = 0;
    e = 0;
    for (int i = 1; i <= n; i++) begin
      if (seq[i]) h++;
      if (seq[i] !== seq[i-1]) e++;
    end
    exp_q.push_back({CW'(sat(h, CW)), CW'(sat(e, CW))});
    exp_s_q.push_back({CW_S'(sat(h, CW_S)), CW_S'(sat(e, CW_S))});

    @(negedge clk);
    dclk         = seq[0];
    window_len   = wl;
    start        = 1'b1;
    result_ready = chained;
    ena          = 1'b1;
    busy_cnt     = 0;
    got          = 1'b0;
    want         = SS + n + gap_len;
    limit        = want + 20;
    for (c = 1; c <= limit; c++) begin
      @(negedge clk);
      start        = (c == ovr_at);
      result_ready = 1'b0;
      window_len   = WW'($urandom);
      if (c <= n) dclk = seq[c];
      else if (c <= n + gap_len) dclk = seq[n];
      else dclk = 1'($urandom);
      ena = !(gap_at != 0 && c >= gap_at && c < gap_at + gap_len);
      #4;
      if (c == 1) begin
        check("accept_busy", 32'(busy), 32'(1));
        check("accept_overrun_clear", 32'(overrun), 32'(0));
      end
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    ena   = 1'b1;
    start = 1'b0;
    if (!got) begin
      check("result_timeout", 32'(0), 32'(1));
      return;
    end
    check("latency", 32'(c - 1), 32'(want));
    check("busy_cycles", 32'(busy_cnt), 32'(want));
    check("busy_low_done", 32'(busy), 32'(0));
    check("small_valid", 32'(result_valid_s), 32'(1));
    check("overrun_flag", 32'(overrun), 32'(ovr_at != 0));
    for (int k = 0; k < ready_delay; k++) begin
      @(negedge clk);
      #4;
      check("hold_valid", 32'(result_valid), 32'(1));
      check("hold_hit", 32'(hit_count), 32'(sat(h, CW)));
      check("hold_edge", 32'(edge_count), 32'(sat(e, CW)));
    end
    if (!hold) begin
      @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      #4;
      check("idle_valid", 32'(result_valid), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #4;
    check("rst_valid", 32'(result_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_hit", 32'(hit_count), 32'(0));
    check("rst_edge", 32'(edge_count), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ena   = 1'b1;

    // constant high, 10 samples
    fill_const(1'b1);
    run_meas(8'd10, 1, 0, 0, 0, 0, 0);
    // alternating, settle ends at 0
    fill_alt();
    run_meas(8'd10, 0, 0, 0, 0, 0, 0);
    // full 256-sample window
    fill_const(1'b1);
    run_meas(8'd0, 0, 0, 0, 0, 0, 0);
    // 40 samples saturate the narrow instance
    fill_const(1'b1);
    run_meas(8'd40, 0, 0, 0, 0, 0, 0);
    // dropped start in ACCUM, then result held 5 cycles without ready
    fill_const(1'b1);
    run_meas(8'd10, 5, 1, 0, SS + 3, 0, 0);
    // handshake and start together restart directly
    fill_alt();
    run_meas(8'd12, 2, 0, 1, 0, 0, 0);
    // ena low for 3 cycles mid-window freezes the measurement
    fill_const(1'b1);
    run_meas(8'd8, 0, 0, 0, 0, SS + 4, 3);

    // reset in the middle of ACCUM
    fill_const(1'b1);
    @(negedge clk);
    dclk = 1'b1;
    window_len = 8'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("pre_rst_overrun", 32'(overrun), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(result_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_overrun", 32'(overrun), 32'(0));
    check("mid_rst_hit", 32'(hit_count), 32'(0));
    check("mid_rst_edge", 32'(edge_count), 32'(0));
    check("mid_rst_s_hit", 32'(hit_count_s), 32'(0));
    #1;
    rst_n = 1'b1;
    fill_alt();
    run_meas(8'd7, 1, 0, 0, 0, 0, 0);

    // randomized windows and sample streams
    for (int r = 0; r < 30; r++) begin
      logic [WW-1:0] wl;
      wl = ($urandom_range(0, 9) == 0) ? 8'd0 : WW'($urandom_range(1, 48));
      fill_rand();
      run_meas(wl, $urandom_range(0, 3), 0, 0, 0, 0, 0);
    end

    repeat (4) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'(0));
    check("drain_s", 32'(exp_s_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
